// File: rtl/x_rom_fetch.sv
// x_rom_fetch: walks the X operand region of a synchronous ROM row by row,
// absorbs the one-cycle ROM latency in a two-entry registered FIFO and
// presents each word downstream with a valid/ready handshake plus its
// column index within the row.
module x_rom_fetch #(
    parameter int ADDR_W        = 6,
    parameter int BASE_ADDR     = 0,
    parameter int ROWS          = 8,
    parameter int WORDS_PER_ROW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              x_ready,
    output logic              x_valid,
    output logic [31:0]       x_data,
    output logic [2:0]        col_counter,
    output logic              row_done,
    output logic              busy,
    output logic              frame_done
);

    localparam int TOTAL = ROWS * WORDS_PER_ROW;
    localparam int CNT_W = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  accepted_q, accepted_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [31:0]       head_q, head_d;
    logic [31:0]       tail_q, tail_d;
    logic [2:0]        col_q, col_d;

    logic              push;
    logic              pop;
    logic              last_pop;
    logic              frame_start;
    logic [2:0]        occ;

    // A ROM read issued last cycle returns data now; the FIFO head is the
    // downstream word, so a transfer is simply head-valid and ready.
    assign push        = inflight_q;
    assign x_valid     = (fifo_cnt_q != 2'd0);
    assign pop         = x_valid && x_ready;
    assign last_pop    = pop && (accepted_q == CNT_W'(TOTAL - 1));
    assign frame_start = (state_q == S_IDLE) && start;
    assign occ         = {1'b0, fifo_cnt_q} + {2'b0, inflight_q};
    assign x_data      = head_q;
    assign col_counter = col_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the frame ends on acceptance of the final word,
    // and DONE lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: if (last_pop) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: a read is issued only while words remain and the FIFO is
    // guaranteed a free slot for the returning data, counting the word
    // leaving this cycle.
    always_comb begin
        rom_en     = 1'b0;
        rom_addr   = '0;
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_DONE);
        row_done   = pop && (col_q == 3'(WORDS_PER_ROW - 1));
        if ((state_q == S_FETCH) && (issued_q < CNT_W'(TOTAL)) &&
            (occ < (3'd2 + {2'b0, pop}))) begin
            rom_en   = 1'b1;
            rom_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(issued_q);
        end
    end

    // Counters and column tracking; all restart at the beginning of a frame.
    always_comb begin
        issued_d   = issued_q;
        accepted_d = accepted_q;
        col_d      = col_q;
        inflight_d = rom_en;
        if (frame_start) begin
            issued_d   = '0;
            accepted_d = '0;
            col_d      = 3'd0;
        end else begin
            if (rom_en) begin
                issued_d = issued_q + CNT_W'(1);
            end
            if (pop) begin
                accepted_d = accepted_q + CNT_W'(1);
                if (col_q == 3'(WORDS_PER_ROW - 1)) begin
                    col_d = 3'd0;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
        end
    end

    // Two-entry FIFO: head feeds x_data directly; a simultaneous push and
    // pop while full shifts the tail forward and refills it, keeping order.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        fifo_cnt_d = fifo_cnt_q;
        unique case ({push, pop})
            2'b10: begin
                if (fifo_cnt_q == 2'd0) begin
                    head_d = rom_data;
                end else begin
                    tail_d = rom_data;
                end
                fifo_cnt_d = fifo_cnt_q + 2'd1;
            end
            2'b01: begin
                head_d     = tail_q;
                fifo_cnt_d = fifo_cnt_q - 2'd1;
            end
            2'b11: begin
                if (fifo_cnt_q == 2'd1) begin
                    head_d = rom_data;
                end else begin
                    head_d = tail_q;
                    tail_d = rom_data;
                end
            end
            default: ;
        endcase
    end

    // Datapath and counter registers; reset drops any read still in flight
    // so the data returning next cycle is not captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
            fifo_cnt_q <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            col_q      <= 3'd0;
        end else begin
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            col_q      <= col_d;
        end
    end

endmodule

// File: tb/tb_x_rom_fetch.sv
// Testbench for x_rom_fetch: three instances with different geometries,
// each backed by a behavioural synchronous ROM.
module tb_x_rom_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] word_at(input int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    // Instance A: ROWS=2, WORDS_PER_ROW=2, BASE_ADDR=4
    logic        a_rst = 1'b1, a_start = 1'b0, a_ready = 1'b0;
    logic        a_rom_en, a_valid, a_row_done, a_busy, a_fd;
    logic [5:0]  a_rom_addr;
    logic [31:0] a_rom_data = '0, a_data;
    logic [2:0]  a_col;

    x_rom_fetch #(.ADDR_W(6), .BASE_ADDR(4), .ROWS(2), .WORDS_PER_ROW(2)) u_a (
        .clk(clk), .rst(a_rst), .start(a_start), .rom_en(a_rom_en),
        .rom_addr(a_rom_addr), .rom_data(a_rom_data), .x_ready(a_ready),
        .x_valid(a_valid), .x_data(a_data), .col_counter(a_col),
        .row_done(a_row_done), .busy(a_busy), .frame_done(a_fd));

    always @(posedge clk) if (a_rom_en) a_rom_data <= word_at(int'(a_rom_addr));

    // Instance B: ROWS=8, WORDS_PER_ROW=3, BASE_ADDR=0
    logic        b_rst = 1'b1, b_start = 1'b0, b_ready = 1'b0;
    logic        b_rom_en, b_valid, b_row_done, b_busy, b_fd;
    logic [5:0]  b_rom_addr;
    logic [31:0] b_rom_data = '0, b_data;
    logic [2:0]  b_col;

    x_rom_fetch #(.ADDR_W(6), .BASE_ADDR(0), .ROWS(8), .WORDS_PER_ROW(3)) u_b (
        .clk(clk), .rst(b_rst), .start(b_start), .rom_en(b_rom_en),
        .rom_addr(b_rom_addr), .rom_data(b_rom_data), .x_ready(b_ready),
        .x_valid(b_valid), .x_data(b_data), .col_counter(b_col),
        .row_done(b_row_done), .busy(b_busy), .frame_done(b_fd));

    always @(posedge clk) if (b_rom_en) b_rom_data <= word_at(int'(b_rom_addr));

    // Instance C: ROWS=3, WORDS_PER_ROW=1, BASE_ADDR=10
    logic        c_rst = 1'b1, c_start = 1'b0, c_ready = 1'b0;
    logic        c_rom_en, c_valid, c_row_done, c_busy, c_fd;
    logic [5:0]  c_rom_addr;
    logic [31:0] c_rom_data = '0, c_data;
    logic [2:0]  c_col;

    x_rom_fetch #(.ADDR_W(6), .BASE_ADDR(10), .ROWS(3), .WORDS_PER_ROW(1)) u_c (
        .clk(clk), .rst(c_rst), .start(c_start), .rom_en(c_rom_en),
        .rom_addr(c_rom_addr), .rom_data(c_rom_data), .x_ready(c_ready),
        .x_valid(c_valid), .x_data(c_data), .col_counter(c_col),
        .row_done(c_row_done), .busy(c_busy), .frame_done(c_fd));

    always @(posedge clk) if (c_rom_en) c_rom_data <= word_at(int'(c_rom_addr));

    // Advance to just after the next rising edge; inputs are driven here and
    // outputs sampled 2 time units later, well away from either edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic reset_all();
        next_cycle();
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
        next_cycle();
        next_cycle();
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_all();
        settle();
        checks++; if (a_rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en got %0b want 0", a_rom_en); end
        checks++; if (a_rom_addr !== 6'd0) begin errors++; $display("FAIL reset_rom_addr got %0d want 0", a_rom_addr); end
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_x_valid got %0b want 0", a_valid); end
        checks++; if (a_data !== 32'd0) begin errors++; $display("FAIL reset_x_data got %h want 0", a_data); end
        checks++; if (a_col !== 3'd0) begin errors++; $display("FAIL reset_col got %0d want 0", a_col); end
        checks++; if ({a_row_done, a_busy, a_fd} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {a_row_done, a_busy, a_fd}); end
        checks++; if ({b_busy, c_busy, b_valid, c_valid} !== 4'b0000) begin errors++; $display("FAIL reset_bc got %b want 0000", {b_busy, c_busy, b_valid, c_valid}); end
    endtask

    // x_ready held high, start at cycle 0; full cycle-by-cycle table.
    task automatic test_basic();
        bit exp_en[9]    = '{0, 1, 1, 1, 1, 0, 0, 0, 0};
        bit exp_valid[9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
        bit exp_row[9]   = '{0, 0, 0, 0, 1, 0, 1, 0, 0};
        bit exp_fd[9]    = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        bit exp_busy[9]  = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
        int exp_col[9]   = '{0, 0, 0, 0, 1, 0, 1, 0, 0};
        reset_all();
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            a_start = (c == 0);
            a_ready = 1'b1;
            settle();
            checks++; if (a_rom_en !== exp_en[c]) begin errors++; $display("FAIL basic_rom_en c%0d got %0b want %0b", c, a_rom_en, exp_en[c]); end
            if (exp_en[c]) begin
                checks++; if (a_rom_addr !== 6'(3 + c)) begin errors++; $display("FAIL basic_addr c%0d got %0d want %0d", c, a_rom_addr, 3 + c); end
            end
            checks++; if (a_valid !== exp_valid[c]) begin errors++; $display("FAIL basic_valid c%0d got %0b want %0b", c, a_valid, exp_valid[c]); end
            if (exp_valid[c]) begin
                checks++; if (a_data !== word_at(1 + c)) begin errors++; $display("FAIL basic_data c%0d got %h want %h", c, a_data, word_at(1 + c)); end
                checks++; if (a_col !== 3'(exp_col[c])) begin errors++; $display("FAIL basic_col c%0d got %0d want %0d", c, a_col, exp_col[c]); end
            end
            checks++; if (a_row_done !== exp_row[c]) begin errors++; $display("FAIL basic_row_done c%0d got %0b want %0b", c, a_row_done, exp_row[c]); end
            checks++; if (a_fd !== exp_fd[c]) begin errors++; $display("FAIL basic_frame_done c%0d got %0b want %0b", c, a_fd, exp_fd[c]); end
            checks++; if (a_busy !== exp_busy[c]) begin errors++; $display("FAIL basic_busy c%0d got %0b want %0b", c, a_busy, exp_busy[c]); end
        end
        a_start = 1'b0;
    endtask

    // x_ready low in cycles 3..8; exactly two reads before the stall.
    task automatic test_backpressure();
        int en_early = 0, hold_bad = 0;
        bit seen_fd = 0;
        logic [31:0] acc[$];
        reset_all();
        for (int c = 0; c < 40 && !seen_fd; c++) begin
            next_cycle();
            a_start = (c == 0);
            a_ready = !(c >= 3 && c <= 8);
            settle();
            if (c <= 8 && a_rom_en) en_early++;
            if (c >= 3 && c <= 8 && !(a_valid === 1'b1 && a_data === word_at(4))) hold_bad++;
            if (a_valid && a_ready) acc.push_back(a_data);
            if (a_fd) seen_fd = 1;
        end
        a_start = 1'b0;
        checks++; if (en_early != 2) begin errors++; $display("FAIL stall_reads got %0d want 2", en_early); end
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL stall_hold bad_cycles %0d want 0", hold_bad); end
        checks++; if (!seen_fd) begin errors++; $display("FAIL stall_frame_done got 0 want 1 (timeout)"); end
        checks++; if (acc.size() != 4) begin errors++; $display("FAIL stall_count got %0d want 4", acc.size()); end
        for (int i = 0; i < acc.size() && i < 4; i++) begin
            checks++; if (acc[i] !== word_at(4 + i)) begin errors++; $display("FAIL stall_order i%0d got %h want %h", i, acc[i], word_at(4 + i)); end
        end
    endtask

    // A second start at cycle 2 is ignored.
    task automatic test_start_ignored();
        int addrs[$];
        int fd_cnt = 0, fd_cyc = -1;
        reset_all();
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            a_start = (c == 0 || c == 2);
            a_ready = 1'b1;
            settle();
            if (a_rom_en) addrs.push_back(int'(a_rom_addr));
            if (a_fd) begin fd_cnt++; fd_cyc = c; end
        end
        a_start = 1'b0;
        checks++; if (addrs.size() != 4) begin errors++; $display("FAIL restart_reads got %0d want 4", addrs.size()); end
        for (int i = 0; i < addrs.size() && i < 4; i++) begin
            checks++; if (addrs[i] != 4 + i) begin errors++; $display("FAIL restart_addr i%0d got %0d want %0d", i, addrs[i], 4 + i); end
        end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL restart_fd_count got %0d want 1", fd_cnt); end
        checks++; if (fd_cyc != 7) begin errors++; $display("FAIL restart_fd_cycle got %0d want 7", fd_cyc); end
    endtask

    // Reset at cycle 4 with word 5 in the FIFO and word 6 in flight.
    task automatic test_reset_mid_frame();
        bit seen_fd = 0;
        logic [31:0] acc[$];
        reset_all();
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            a_start = (c == 0);
            a_ready = (c <= 3);
            a_rst   = (c == 4);
            settle();
            if (c == 4) begin
                checks++; if (a_valid !== 1'b1 || a_col !== 3'd1) begin errors++; $display("FAIL midrst_pre got valid=%0b col=%0d want valid=1 col=1", a_valid, a_col); end
            end
        end
        next_cycle();
        a_rst = 1'b0;
        settle();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b want 0", a_valid); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b want 0", a_busy); end
        checks++; if (a_col !== 3'd0) begin errors++; $display("FAIL midrst_col got %0d want 0", a_col); end
        checks++; if (a_rom_en !== 1'b0) begin errors++; $display("FAIL midrst_rom_en got %0b want 0", a_rom_en); end
        next_cycle();
        settle();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL midrst_late_data got valid %0b want 0", a_valid); end
        next_cycle();
        a_start = 1'b1;
        a_ready = 1'b1;
        settle();
        next_cycle();
        a_start = 1'b0;
        settle();
        checks++; if (a_rom_en !== 1'b1 || a_rom_addr !== 6'd4) begin errors++; $display("FAIL midrst_refetch got en=%0b addr=%0d want en=1 addr=4", a_rom_en, a_rom_addr); end
        for (int c = 0; c < 20 && !seen_fd; c++) begin
            if (a_valid && a_ready) acc.push_back(a_data);
            if (a_fd) seen_fd = 1;
            next_cycle();
            settle();
        end
        checks++; if (acc.size() != 4 || acc[0] !== word_at(4)) begin errors++; $display("FAIL midrst_words got n=%0d first=%h want n=4 first=%h", acc.size(), (acc.size() > 0) ? acc[0] : 32'hx, word_at(4)); end
    endtask

    // 50% random backpressure over the default 8x3 frame.
    task automatic test_random_backpressure();
        int pops = 0, rd_cnt = 0, fd_cnt = 0, bad_data = 0, bad_col = 0, bad_rd = 0;
        int tail = -1;
        reset_all();
        for (int c = 0; c < 600 && tail != 0; c++) begin
            next_cycle();
            b_start = (c == 0);
            b_ready = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            settle();
            if (b_valid && b_ready) begin
                if (b_data !== word_at(pops)) bad_data++;
                if (b_col !== 3'(pops % 3)) bad_col++;
                if (b_row_done !== (pops % 3 == 2)) bad_rd++;
                pops++;
            end else if (b_row_done) begin
                bad_rd++;
            end
            if (b_row_done) rd_cnt++;
            if (b_fd) begin fd_cnt++; if (tail < 0) tail = 4; end
            if (tail > 0) tail--;
        end
        b_start = 1'b0;
        b_ready = 1'b0;
        checks++; if (pops != 24) begin errors++; $display("FAIL rand_pops got %0d want 24", pops); end
        checks++; if (bad_data != 0) begin errors++; $display("FAIL rand_order bad_words %0d want 0", bad_data); end
        checks++; if (bad_col != 0) begin errors++; $display("FAIL rand_col bad_cols %0d want 0", bad_col); end
        checks++; if (bad_rd != 0) begin errors++; $display("FAIL rand_row_done_place bad %0d want 0", bad_rd); end
        checks++; if (rd_cnt != 8) begin errors++; $display("FAIL rand_row_done_count got %0d want 8", rd_cnt); end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL rand_frame_done_count got %0d want 1", fd_cnt); end
    endtask

    // WORDS_PER_ROW=1: every accepted word closes a row.
    task automatic test_single_word_rows();
        int pops = 0, bad = 0;
        bit seen_fd = 0;
        reset_all();
        for (int c = 0; c < 30 && !seen_fd; c++) begin
            next_cycle();
            c_start = (c == 0);
            c_ready = 1'b1;
            settle();
            if (c_valid && c_ready) begin
                if (c_row_done !== 1'b1 || c_col !== 3'd0 || c_data !== word_at(10 + pops)) bad++;
                pops++;
            end
            if (c_fd) seen_fd = 1;
        end
        c_start = 1'b0;
        checks++; if (pops != 3) begin errors++; $display("FAIL wpr1_pops got %0d want 3", pops); end
        checks++; if (bad != 0) begin errors++; $display("FAIL wpr1_row_done_col bad %0d want 0", bad); end
        checks++; if (!seen_fd) begin errors++; $display("FAIL wpr1_frame_done got 0 want 1 (timeout)"); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_frame();
        test_random_backpressure();
        test_single_word_rows();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
